// File: rtl/err_inject_ctrl.sv
// ---------------------------------------------------------------------------
// err_inject_ctrl
//
// Streaming fault-injection stage placed between an ECC encoder and decoder.
// Words pass through a single valid/ready register stage. While a run is
// armed, a scheduled subset of accepted words is XORed with an error mask:
// single-bit, double-bit or a contiguous burst.
//
// Schedule: the first accepted word after arm is corrupted, then every
// (interval+1)-th accepted word, for cfg_count injections (0 = unlimited).
//
// Optional feature (compile-time macro ERR_INJ_LFSR_EN):
//   A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances
//   every cycle. With latched cfg_rand = 1, pos0 for each injection is taken
//   from the LFSR, folded into 0..DATA_W-1. Without the macro no LFSR is
//   built and cfg_rand is ignored.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid / in_ready / in_data    upstream stream
//   out_valid / out_ready / out_data downstream stream (data XOR mask)
//   out_mask                         mask applied to out_data (0 = clean)
//   cfg_mode                         0 off, 1 single, 2 double, 3 burst
//   cfg_pos0, cfg_pos1               bit positions
//   cfg_burst_len                    burst length (0 treated as 1)
//   cfg_interval                     clean words between injections
//   cfg_count                        injections per run (0 = unlimited)
//   cfg_rand                         random pos0 (LFSR build only)
//   arm, disarm                      one-cycle run-control pulses
//   busy                             run in progress
//   done                             pulse after the final counted injection
//   inj_total                        saturating injected-word count
// ---------------------------------------------------------------------------
module err_inject_ctrl #(
    parameter int unsigned DATA_W = 72,
    parameter int unsigned POS_W  = $clog2(DATA_W),
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_mask,
    input  logic [1:0]        cfg_mode,
    input  logic [POS_W-1:0]  cfg_pos0,
    input  logic [POS_W-1:0]  cfg_pos1,
    input  logic [POS_W-1:0]  cfg_burst_len,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_rand,
    input  logic              arm,
    input  logic              disarm,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  inj_total
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [POS_W-1:0]    pos0_q;
    logic [POS_W-1:0]    pos1_q;
    logic [POS_W-1:0]    blen_q;
    logic [CNT_W-1:0]    interval_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    gap_q;
    logic [CNT_W-1:0]    remain_q;
    logic [CNT_W-1:0]    inj_total_q;
    logic                done_q;

    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W-1:0]   out_mask_q;

    logic                accept;
    logic                inject;
    logic                last_inj;
    logic [POS_W-1:0]    pos0_eff;
    logic [DATA_W-1:0]   mask_d;
    logic [DATA_W-1:0]   applied_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign inject    = (state_q == ST_RUN) && accept && (gap_q == '0);
    assign last_inj  = inject && (count_q != '0) && (remain_q == CNT_W'(1));
    assign applied_d = inject ? mask_d : '0;

`ifdef ERR_INJ_LFSR_EN
    logic [15:0]      lfsr_q;
    logic             rand_q;
    logic [POS_W-1:0] lfsr_pos;
    int unsigned      lfsr_raw;

    // Fold the raw LFSR slice into range with a single subtraction.
    always_comb begin
        lfsr_raw = 32'(lfsr_q[POS_W-1:0]);
        if (lfsr_raw >= DATA_W) begin
            lfsr_pos = POS_W'(lfsr_raw - DATA_W);
        end else begin
            lfsr_pos = POS_W'(lfsr_raw);
        end
    end

    assign pos0_eff = rand_q ? lfsr_pos : pos0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
            rand_q <= 1'b0;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            if (arm) begin
                rand_q <= cfg_rand;
            end
        end
    end
`else
    logic unused_cfg_rand;
    assign unused_cfg_rand = cfg_rand;
    assign pos0_eff        = pos0_q;
`endif

    // Mask construction. Positions at or beyond DATA_W never match an index,
    // so out-of-range positions and burst tails drop out naturally.
    always_comb begin
        int unsigned p0;
        int unsigned p1;
        int unsigned len;
        mask_d = '0;
        p0     = 32'(pos0_eff);
        p1     = 32'(pos1_q);
        len    = (blen_q == '0) ? 32'd1 : 32'(blen_q);
        for (int unsigned i = 0; i < DATA_W; i++) begin
            case (mode_q)
                2'd1:    mask_d[i] = (i == p0);
                2'd2:    mask_d[i] = (i == p0) || (i == p1);
                2'd3:    mask_d[i] = (i >= p0) && (i < p0 + len);
                default: mask_d[i] = 1'b0;
            endcase
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data ^ applied_d;
            out_mask_q  <= applied_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Run-control FSM. The word accepted in any cycle is judged against the
    // state before that edge, so a word coinciding with disarm is still
    // injected under RUN rules; arm overrides the schedule update and disarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            pos0_q      <= '0;
            pos1_q      <= '0;
            blen_q      <= '0;
            interval_q  <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            remain_q    <= '0;
            inj_total_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (inject && (inj_total_q != '1)) begin
                inj_total_q <= inj_total_q + CNT_W'(1);
            end
            if (arm) begin
                state_q    <= ST_RUN;
                mode_q     <= cfg_mode;
                pos0_q     <= cfg_pos0;
                pos1_q     <= cfg_pos1;
                blen_q     <= cfg_burst_len;
                interval_q <= cfg_interval;
                count_q    <= cfg_count;
                gap_q      <= '0;
                remain_q   <= cfg_count;
            end else begin
                if (inject) begin
                    gap_q <= interval_q;
                    if (count_q != '0) begin
                        remain_q <= remain_q - CNT_W'(1);
                    end
                end else if ((state_q == ST_RUN) && accept) begin
                    gap_q <= gap_q - CNT_W'(1);
                end
                if (last_inj) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                if (disarm) begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mask  = out_mask_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign inj_total = inj_total_q;

endmodule

// File: tb/tb_err_inject_ctrl.sv
// ---------------------------------------------------------------------------
// tb_err_inject_ctrl
//
// Scoreboard bench for err_inject_ctrl (DATA_W = 72). A behavioural model of
// the injection schedule runs alongside the stimulus; each accepted word
// pushes its expected output onto a queue, popped when the DUT hands a word
// downstream. busy, done and inj_total are compared every cycle.
// ---------------------------------------------------------------------------
module tb_err_inject_ctrl;

    localparam int unsigned DW = 72;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [DW-1:0] out_mask;
    logic [1:0]    cfg_mode;
    logic [6:0]    cfg_pos0;
    logic [6:0]    cfg_pos1;
    logic [6:0]    cfg_burst_len;
    logic [15:0]   cfg_interval;
    logic [15:0]   cfg_count;
    logic          cfg_rand;
    logic          arm;
    logic          disarm;
    logic          busy;
    logic          done;
    logic [15:0]   inj_total;

    err_inject_ctrl #(.DATA_W(72), .POS_W(7), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mask(out_mask),
        .cfg_mode(cfg_mode), .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1),
        .cfg_burst_len(cfg_burst_len), .cfg_interval(cfg_interval),
        .cfg_count(cfg_count), .cfg_rand(cfg_rand),
        .arm(arm), .disarm(disarm),
        .busy(busy), .done(done), .inj_total(inj_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [DW-1:0] din;
        bit            rnd;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_run;
    logic [1:0]  m_mode;
    logic [6:0]  m_p0, m_p1, m_len;
    logic [15:0] m_int, m_cnt, m_gap, m_rem, m_total;
    bit          m_rand;
    bit          m_done;

    bit            stall_prev;
    logic [DW-1:0] prev_data, prev_mask;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_mask(input logic [1:0] mode, input logic [6:0] p0,
                                               input logic [6:0] p1, input logic [6:0] len);
        logic [255:0] w;
        int unsigned  l;
        w = '0;
        l = (len == 0) ? 1 : int'(len);
        case (mode)
            2'd1: w = 256'(1) << p0;
            2'd2: w = (256'(1) << p0) | (256'(1) << p1);
            2'd3: w = ((256'(1) << l) - 256'(1)) << p0;
            default: w = '0;
        endcase
        return w[DW-1:0];
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_p0 = 0; m_p1 = 0; m_len = 0;
        m_int = 0; m_cnt = 0; m_gap = 0; m_rem = 0; m_total = 0;
        m_rand = 0; m_done = 0; stall_prev = 0;
        sb_q.delete();
    endtask

    // One clock cycle: inputs are already driven; check the handshake that
    // is about to happen, advance the model, then cross the edge.
    task automatic step();
        bit   acc, inj;
        exp_t e;
        logic [DW-1:0] em;
        #2;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                if (e.rnd) begin
                    check_eq("rand_onehot", 128'($countones(out_mask)), 1);
                    check_eq("rand_data", out_data ^ out_mask, e.din);
                end else begin
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_mask", out_mask, e.mask);
                end
            end
        end
        if (stall_prev) begin
            check_eq("hold_data", out_data, prev_data);
            check_eq("hold_mask", out_mask, prev_mask);
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_mask  = out_mask;

        inj = m_run && acc && (m_gap == 0);
        if (acc) begin
            em = inj ? ref_mask(m_mode, m_p0, m_p1, m_len) : '0;
            e.data = in_data ^ em;
            e.mask = em;
            e.din  = in_data;
            e.rnd  = inj && m_rand && (m_mode == 2'd1);
            sb_q.push_back(e);
        end
        m_done = 0;
        if (inj && m_total != 16'hFFFF) m_total++;
        if (arm) begin
            m_run = 1; m_mode = cfg_mode; m_p0 = cfg_pos0; m_p1 = cfg_pos1;
            m_len = cfg_burst_len; m_int = cfg_interval; m_cnt = cfg_count;
            m_gap = 0; m_rem = cfg_count;
`ifdef ERR_INJ_LFSR_EN
            m_rand = cfg_rand;
`endif
        end else begin
            if (inj) begin
                m_gap = m_int;
                if (m_cnt != 0) begin
                    if (m_rem == 1) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                    m_rem--;
                end
            end else if (m_run && acc) begin
                m_gap--;
            end
            if (disarm) m_run = 0;
        end
        @(posedge clk);
        #1;
        check_eq("busy", busy, m_run);
        check_eq("done", done, m_done);
        check_eq("inj_total", inj_total, m_total);
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] len, input logic [15:0] intv, input logic [15:0] cnt,
                          input logic rnd);
        cfg_mode = mode; cfg_pos0 = p0; cfg_pos1 = p1; cfg_burst_len = len;
        cfg_interval = intv; cfg_count = cnt; cfg_rand = rnd;
        in_valid = 0; arm = 1;
        step();
        arm = 0;
        cfg_mode = 0; cfg_pos0 = 0; cfg_pos1 = 0; cfg_burst_len = 0;
        cfg_interval = 0; cfg_count = 0; cfg_rand = 0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            in_data  = DW'({$urandom, $urandom, $urandom});
            step();
        end
        in_valid = 0;
    endtask

    task automatic drain();
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < 8; i++) step();
        check_eq("drain_empty", 128'(sb_q.size()), 0);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; out_ready = 1;
        cfg_mode = 0; cfg_pos0 = 0; cfg_pos1 = 0; cfg_burst_len = 0;
        cfg_interval = 0; cfg_count = 0; cfg_rand = 0; arm = 0; disarm = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_mask", out_mask, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_inj_total", inj_total, 0);
        rst_n = 1;

        // Passthrough without arm
        stream(100);
        drain();

        // Single, interval 2, count 3: words 0, 3, 6 corrupted at bit 5
        do_arm(2'd1, 7'd5, 7'd0, 7'd0, 16'd2, 16'd3, 0);
        stream(10);
        drain();
        check_eq("single_total", inj_total, 3);

        // Double: edge positions, coincident positions, out-of-range pos0
        do_arm(2'd2, 7'd71, 7'd0, 7'd0, 16'd0, 16'd1, 0);
        stream(3);
        do_arm(2'd2, 7'd9, 7'd9, 7'd0, 16'd0, 16'd1, 0);
        stream(2);
        do_arm(2'd1, 7'd80, 7'd0, 7'd0, 16'd0, 16'd1, 0);
        stream(2);
        drain();

        // Burst clipping and zero length
        do_arm(2'd3, 7'd68, 7'd0, 7'd8, 16'd0, 16'd1, 0);
        stream(2);
        do_arm(2'd3, 7'd68, 7'd0, 7'd0, 16'd0, 16'd1, 0);
        stream(2);
        do_arm(2'd3, 7'd10, 7'd0, 7'd5, 16'd1, 16'd2, 0);
        stream(5);
        drain();

        // Backpressure during an unlimited run
        do_arm(2'd2, 7'd3, 7'd40, 7'd0, 16'd1, 16'd0, 0);
        for (int i = 0; i < 300; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            in_data   = DW'({$urandom, $urandom, $urandom});
            step();
        end
        drain();

        // arm and disarm together: arm wins
        cfg_mode = 2'd1; cfg_pos0 = 7'd2; cfg_interval = 16'd1; cfg_count = 16'd0;
        arm = 1; disarm = 1;
        step();
        arm = 0; disarm = 0;
        stream(4);

        // Re-arm mid-run: next accepted word uses the new position
        do_arm(2'd1, 7'd1, 7'd0, 7'd0, 16'd3, 16'd0, 0);
        stream(2);
        do_arm(2'd1, 7'd7, 7'd0, 7'd0, 16'd3, 16'd0, 0);
        stream(3);
        disarm = 1;
        step();
        disarm = 0;
        stream(3);
        drain();

        // Asynchronous reset mid-run with a stalled word in flight
        do_arm(2'd1, 7'd4, 7'd0, 7'd0, 16'd0, 16'd0, 0);
        out_ready = 0;
        stream(2);
        #2;
        rst_n = 0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out_data", out_data, 0);
        check_eq("arst_out_mask", out_mask, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_inj_total", inj_total, 0);
        model_reset();
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        step();
        stream(4);
        drain();

`ifdef ERR_INJ_LFSR_EN
        do_arm(2'd1, 7'd0, 7'd0, 7'd0, 16'd0, 16'd0, 1);
        stream(60);
        disarm = 1;
        step();
        disarm = 0;
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/err_inject_ctrl.md
# err_inject_ctrl

Parametrised, streaming fault-injection stage for ECC verification. It sits between the ECC encoder output and the decoder input. On a scheduled subset of the words passing through, it XORs an error mask onto the codeword: single-bit, double-bit or burst. The schedule is a programmable interval and a programmable count. It replaces the combinational single-bit flipper with a registered valid/ready stage that has configurable width, injection modes and its own run control.

## Interface
Parameters:
- DATA_W, 72, codeword width in bits (≥ 2).
- POS_W, $clog2(DATA_W), width of the bit-position fields.
- CNT_W, 16, width of the interval, count and statistics counters.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  DATA_W  upstream codeword.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  codeword XOR injected mask.
- out_mask  out  DATA_W  mask applied to the current out_data; all-zero means the word is clean.
- cfg_mode  in  2  0 = off, 1 = single, 2 = double, 3 = burst.
- cfg_pos0  in  POS_W  first or only bit position.
- cfg_pos1  in  POS_W  second position (double mode).
- cfg_burst_len  in  POS_W  burst length; 0 is treated as 1.
- cfg_interval  in  CNT_W  clean words between injections.
- cfg_count  in  CNT_W  injections per run; 0 = unlimited.
- cfg_rand  in  1  random pos0 (see Configuration).
- arm  in  1  one-cycle pulse: latch the cfg_* inputs and start a run.
- disarm  in  1  one-cycle pulse: stop the run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when cfg_count injections are complete.
- inj_total  out  CNT_W  saturating count of injected words since reset.

## Operation
State machine:
- IDLE: passthrough with zero mask. arm -> RUN.
- RUN: injects according to the latched configuration.
  - disarm -> IDLE.
  - Completing the last of a nonzero count -> IDLE, with done asserted.
  - arm while in RUN reloads the configuration and counters and stays in RUN.

Run control:
- cfg_* inputs are latched only on arm. Changes during a run are ignored.
- A word is "accepted" when in_valid && in_ready.
- In RUN, the gap counter is loaded with 0 on arm. An accepted word with gap == 0 is corrupted, and gap reloads to the latched interval. Otherwise gap decrements.
- Result: the first accepted word after arm is corrupted, then every (interval+1)-th word.

Mask construction (in bit-index order):
- single: one-hot(pos0).
- double: one-hot(pos0) OR one-hot(pos1). If pos0 == pos1, the result is a single flip.
- burst: bits pos0 through min(pos0+len-1, DATA_W-1). No wrap-around.
- Any position ≥ DATA_W contributes no bit. A mask of all zero still counts as an injection.
- mode 0 in RUN: words pass clean, but the gap and count logic still runs.

Counters and priority:
- inj_total increments per corrupted accepted word and saturates at all-ones.
- Remaining-count decrements per injection. done pulses in the cycle after the accepting edge of the final injection.
- Simultaneous arm and disarm: arm wins.
- disarm in the same cycle as an accepted word: that word is still evaluated under RUN rules.

## Timing
- Single register stage. Latency is 1 cycle from acceptance to out_valid.
- in_ready = !out_valid || out_ready. Full throughput, one word per cycle, is sustained.
- out_data and out_mask hold stable while out_valid && !out_ready.
- busy rises the cycle after arm and falls the cycle after the terminating event.

Reset values:
- out_valid 0, out_data 0, out_mask 0.
- busy 0, done 0, inj_total 0.
- State IDLE; latched configuration 0.

Reset mid-run discards the in-flight word and any pending done.

## Configuration
- ERR_INJ_LFSR_EN defined:
  - A 16-bit Galois LFSR is included: x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset, advancing every cycle.
  - When the latched cfg_rand = 1, pos0 for each injection is lfsr[POS_W-1:0], minus DATA_W if that value is ≥ DATA_W.
  - pos1 and burst_len still come from configuration.
- ERR_INJ_LFSR_EN undefined: no LFSR is built and cfg_rand is ignored. pos0 always comes from cfg_pos0.

## Test plan
- Passthrough: no arm; stream 100 random words -> out_data == in_data, out_mask == 0, latency 1, inj_total 0.
- Single, interval 2, count 3: arm with mode 1, pos0 5; stream 10 words -> words 0, 3 and 6 have bit 5 flipped; done pulses once; busy falls; inj_total 3.
- Double and edge positions: pos0 71, pos1 0 -> mask 72'h80_0000_0000_0000_0001. pos0 = pos1 = 9 -> single flip. pos0 80 -> mask 0 but inj_total increments.
- Burst clipping: mode 3, pos0 68, len 8 -> mask bits 68..71 only; len 0 -> bit 68 only.
- Backpressure: toggle out_ready randomly at 50% during an unlimited run -> no word lost, duplicated or altered while stalled; the injection pattern follows accepted words, not cycles.
- Control corners:
  - arm+disarm together -> RUN.
  - Re-arm mid-run -> the next accepted word is corrupted with the new pos.
  - rst_n low mid-run -> all outputs 0 asynchronously.
  - With ERR_INJ_LFSR_EN and cfg_rand = 1, every injected pos is < 72.
